// File: rtl/int_vector_arb_if.sv
// int_vector_arb_if: request/vector/handshake bundle between the interrupt controller/CPU and the vector arbiter.
interface int_vector_arb_if;
  logic [4:0]  interupt;
  logic [4:0]  IP;
  logic        inst_boundary;
  logic        int_ack;
  logic        reti;
  logic        int_req;
  logic [15:0] int_vector;
  logic [3:0]  int_clr;
  logic [1:0]  in_service;
  modport master (
    output interupt, IP, inst_boundary, int_ack, reti,
    input  int_req, int_vector, int_clr, in_service
  );
  modport slave (
    input  interupt, IP, inst_boundary, int_ack, reti,
    output int_req, int_vector, int_clr, in_service
  );
endinterface

// File: rtl/int_vector_arb.sv
// int_vector_arb: two-level 8051-style interrupt arbiter that latches a winner at an instruction boundary and presents its LCALL vector.
module int_vector_arb #(
  parameter logic [15:0] VEC_BASE   = 16'h0003,
  parameter int          VEC_STRIDE = 8
) (
  input logic             clk,
  input logic             rst_n,
  int_vector_arb_if.slave bus
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t     state, state_n;
  logic [2:0] idx, idx_n, pick;
  logic       lvl, lvl_n, hi_act, hi_n, lo_act, lo_n, blk, blk_n;
  logic [3:0] clr, clr_n;
  logic [4:0] hi_elig, lo_elig, cand;
  always_comb begin
    hi_elig = bus.interupt & bus.IP & {5{~hi_act}};
    lo_elig = bus.interupt & ~bus.IP & {5{~(hi_act | lo_act)}};
    cand    = |hi_elig ? hi_elig : lo_elig;
    pick    = cand[0] ? 3'd0 : cand[1] ? 3'd1 : cand[2] ? 3'd2 : cand[3] ? 3'd3 : 3'd4;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      lvl    <= 1'b0;
      hi_act <= 1'b0;
      lo_act <= 1'b0;
      blk    <= 1'b0;
      clr    <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      lvl    <= lvl_n;
      hi_act <= hi_n;
      lo_act <= lo_n;
      blk    <= blk_n;
      clr    <= clr_n;
    end
  // RETI retires the innermost level first; an ack in the same cycle then re-arms its own level.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    lvl_n   = lvl;
    clr_n   = '0;
    hi_n    = hi_act & ~bus.reti;
    lo_n    = lo_act & ~(bus.reti & ~hi_act);
    blk_n   = blk;
    case (state)
      IDLE:
        if (bus.inst_boundary) begin
          if (blk) blk_n = 1'b0;
          else if (|cand) begin
            state_n = REQ;
            idx_n   = pick;
            lvl_n   = |hi_elig;
          end
        end
      REQ:
        if (bus.int_ack) begin
          state_n = IDLE;
          if (lvl) hi_n = 1'b1;
          else lo_n = 1'b1;
          clr_n = (idx != 3'd4) ? 4'd1 << idx[1:0] : 4'd0;
        end
      default: state_n = IDLE;
    endcase
    if (bus.reti) blk_n = 1'b1;
  end
  assign bus.int_req    = state == REQ;
  assign bus.int_vector = bus.int_req ? VEC_BASE + 16'(idx) * 16'(VEC_STRIDE) : 16'h0000;
  assign bus.int_clr    = clr;
  assign bus.in_service = {hi_act, lo_act};
endmodule
